// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: CPU-side port controller for the VDP.
// Decodes Z80 I/O strobes into the data, control and PSG ports. Sequences the
// two-byte control word, holds the VRAM address/code registers and the
// read-ahead buffer, and schedules single VRAM accesses against the renderer's
// slot grant and PSG writes against the PSG's ready signal.
//
// Ports:
//   clock, reset              master clock, async active-high reset
//   io_wr, io_rd              one-cycle CPU I/O strobes
//   ca0, ca6, ca7, cd_in      CPU address bits / write data
//   cd_out                    CPU read data (registered, held until next read)
//   busy                      access pending (CPU WAIT)
//   vram_*                    single-access VRAM request interface
//   reg_*, cram_*             register / colour RAM write pulses
//   psg_we, psg_data          PSG byte write, psg_ready gates it
//   status_in, status_rd      status flags and read-clear pulse
//
// state | meaning
// IDLE  | accepting strobes
// VREQ  | vram_req held until vram_ack
// PSGW  | psg_data held until psg_ready, then one psg_we pulse
module vdp_cpu_port #(
  parameter int ADDR_W = 14,
  parameter int NREGS  = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_wr,
  input  logic              io_rd,
  input  logic              ca0,
  input  logic              ca6,
  input  logic              ca7,
  input  logic [7:0]        cd_in,
  output logic [7:0]        cd_out,
  output logic              busy,
  output logic              vram_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic              vram_ack,
  input  logic [7:0]        vram_rdata,
  output logic              reg_we,
  output logic [3:0]        reg_addr,
  output logic [7:0]        reg_data,
  output logic              cram_we,
  output logic [4:0]        cram_addr,
  output logic [7:0]        cram_data,
  output logic              psg_we,
  output logic [7:0]        psg_data,
  input  logic              psg_ready,
  input  logic [7:0]        status_in,
  output logic              status_rd
);

  typedef enum logic [1:0] {IDLE, VREQ, PSGW} state_t;

  localparam logic [4:0] NRegsW = 5'(NREGS);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_t state, nextState;

  logic              firstByte;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        code;
  logic [7:0]        lowLatch;
  logic [7:0]        rbuf;
  logic              reqWe;
  logic [ADDR_W-1:0] reqAddr;
  logic [7:0]        reqWdata;
  logic [7:0]        psgDataQ;

  logic wrStb, rdStb;
  logic psgW, dataW, ctrlW, dataR, ctrlR, lowR;
  logic [ADDR_W-1:0] newAddr;

  // Strobes are only honoured in IDLE; io_wr takes priority over io_rd.
  assign wrStb = io_wr && (state == IDLE);
  assign rdStb = io_rd && !io_wr && (state == IDLE);

  assign psgW  = wrStb && !ca7 && ca6;
  assign dataW = wrStb && ca7 && !ca6 && !ca0;
  assign ctrlW = wrStb && ca7 && !ca6 && ca0;
  assign dataR = rdStb && ca7 && !ca6 && !ca0;
  assign ctrlR = rdStb && ca7 && !ca6 && ca0;
  assign lowR  = rdStb && !ca7;

  // Address formed by the second control byte.
  assign newAddr = {cd_in[ADDR_W-9:0], addr[7:0]};

  assign busy       = (state != IDLE);
  assign vram_req   = (state == VREQ);
  assign vram_we    = reqWe;
  assign vram_addr  = reqAddr;
  assign vram_wdata = reqWdata;
  assign psg_data   = psgDataQ;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    psg_we    = 1'b0;
    case (state)
      IDLE: begin
        if (ctrlW && firstByte && (cd_in[7:6] == 2'd0)) nextState = VREQ;
        else if (dataW && (code != 2'd3))               nextState = VREQ;
        else if (dataR)                                  nextState = VREQ;
        else if (psgW)                                   nextState = PSGW;
      end
      VREQ: if (vram_ack) nextState = IDLE;
      PSGW: begin
        if (psg_ready) begin
          psg_we    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      firstByte <= 1'b0;
      addr      <= '0;
      code      <= 2'd0;
      lowLatch  <= 8'h00;
      rbuf      <= 8'h00;
      reqWe     <= 1'b0;
      reqAddr   <= '0;
      reqWdata  <= 8'h00;
      psgDataQ  <= 8'h00;
      cd_out    <= 8'h00;
      reg_we    <= 1'b0;
      reg_addr  <= 4'h0;
      reg_data  <= 8'h00;
      cram_we   <= 1'b0;
      cram_addr <= 5'h00;
      cram_data <= 8'h00;
      status_rd <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      cram_we   <= 1'b0;
      status_rd <= 1'b0;

      if (ctrlW) begin
        if (!firstByte) begin
          addr[7:0] <= cd_in;
          lowLatch  <= cd_in;
          firstByte <= 1'b1;
        end else begin
          code      <= cd_in[7:6];
          firstByte <= 1'b0;
          if (cd_in[7:6] == 2'd0) begin
            // read-ahead: fetch at the new address, step past it
            reqAddr <= newAddr;
            reqWe   <= 1'b0;
            addr    <= newAddr + AddrOne;
          end else begin
            addr <= newAddr;
          end
          if ((cd_in[7:6] == 2'd2) && ({1'b0, cd_in[3:0]} < NRegsW)) begin
            reg_we   <= 1'b1;
            reg_addr <= cd_in[3:0];
            reg_data <= lowLatch;
          end
        end
      end

      if (ctrlR) begin
        cd_out    <= status_in;
        status_rd <= 1'b1;
        firstByte <= 1'b0;
      end

      if (dataW) begin
        firstByte <= 1'b0;
        addr      <= addr + AddrOne;
        if (code == 2'd3) begin
          cram_we   <= 1'b1;
          cram_addr <= addr[4:0];
          cram_data <= cd_in;
        end else begin
          reqAddr  <= addr;
          reqWe    <= 1'b1;
          reqWdata <= cd_in;
          rbuf     <= cd_in;
        end
      end

      if (dataR) begin
        firstByte <= 1'b0;
        cd_out    <= rbuf;
        reqAddr   <= addr;
        reqWe     <= 1'b0;
        addr      <= addr + AddrOne;
      end

      if (lowR) cd_out <= 8'hFF;

      if (psgW) psgDataQ <= cd_in;

      if ((state == VREQ) && vram_ack && !reqWe) rbuf <= vram_rdata;
    end
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed testbench for vdp_cpu_port. Inputs are driven and outputs sampled
// 1 ns after the rising clock edge.
module tb_vdp_cpu_port;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_wr = 1'b0, io_rd = 1'b0;
  logic        ca0 = 1'b0, ca6 = 1'b0, ca7 = 1'b0;
  logic [7:0]  cd_in = 8'h00;
  logic [7:0]  cd_out;
  logic        busy, vram_req, vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_ack = 1'b0;
  logic [7:0]  vram_rdata = 8'h00;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        cram_we;
  logic [4:0]  cram_addr;
  logic [7:0]  cram_data;
  logic        psg_we;
  logic [7:0]  psg_data;
  logic        psg_ready = 1'b1;
  logic [7:0]  status_in = 8'h00;
  logic        status_rd;

  int nCompared = 0;
  int nMismatched = 0;
  int psgPulses;

  vdp_cpu_port #(.ADDR_W(14), .NREGS(11)) dut (
    .clock(clock), .reset(reset),
    .io_wr(io_wr), .io_rd(io_rd),
    .ca0(ca0), .ca6(ca6), .ca7(ca7),
    .cd_in(cd_in), .cd_out(cd_out), .busy(busy),
    .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .cram_we(cram_we), .cram_addr(cram_addr), .cram_data(cram_data),
    .psg_we(psg_we), .psg_data(psg_data), .psg_ready(psg_ready),
    .status_in(status_in), .status_rd(status_rd)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wrPort(input logic a7, input logic a6, input logic a0, input logic [7:0] d);
    io_wr = 1'b1; ca7 = a7; ca6 = a6; ca0 = a0; cd_in = d;
    cyc();
    io_wr = 1'b0;
  endtask

  task automatic rdPort(input logic a7, input logic a6, input logic a0);
    io_rd = 1'b1; ca7 = a7; ca6 = a6; ca0 = a0;
    cyc();
    io_rd = 1'b0;
  endtask

  task automatic ctrlWr(input logic [7:0] d);
    wrPort(1'b1, 1'b0, 1'b1, d);
  endtask

  task automatic dataWr(input logic [7:0] d);
    wrPort(1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic ackNow(input logic [7:0] rd);
    vram_rdata = rd;
    vram_ack   = 1'b1;
    cyc();
    vram_ack   = 1'b0;
  endtask

  initial begin
    // reset state
    cyc(); cyc();
    check("rst cd_out", 16'(cd_out), 16'h00);
    check("rst busy", 16'(busy), 16'h0);
    check("rst vram_req", 16'(vram_req), 16'h0);
    check("rst reg_we", 16'(reg_we), 16'h0);
    check("rst cram_we", 16'(cram_we), 16'h0);
    check("rst psg_we", 16'(psg_we), 16'h0);
    check("rst status_rd", 16'(status_rd), 16'h0);
    reset = 1'b0;
    cyc();

    // write mode at 0x0234, ack on the third request cycle
    ctrlWr(8'h34);
    ctrlWr(8'h42);
    check("wmode no req", 16'(vram_req), 16'h0);
    dataWr(8'hAA);
    check("wr req c1", 16'(vram_req), 16'h1);
    check("wr we", 16'(vram_we), 16'h1);
    check("wr addr", 16'(vram_addr), 16'h0234);
    check("wr wdata", 16'(vram_wdata), 16'h00AA);
    check("wr busy", 16'(busy), 16'h1);
    cyc();
    check("wr req c2", 16'(vram_req), 16'h1);
    check("wr addr c2", 16'(vram_addr), 16'h0234);
    cyc();
    check("wr req c3", 16'(vram_req), 16'h1);
    ackNow(8'h00);
    check("wr busy after ack", 16'(busy), 16'h0);
    check("wr req after ack", 16'(vram_req), 16'h0);
    // next write goes to 0x0235; ack in first cycle gives 1-cycle busy
    dataWr(8'hBB);
    check("wr2 addr", 16'(vram_addr), 16'h0235);
    check("wr2 wdata", 16'(vram_wdata), 16'h00BB);
    ackNow(8'h00);
    check("wr2 1cyc busy", 16'(busy), 16'h0);

    // read mode at 0x0000 with read-ahead, then data read
    ctrlWr(8'h00);
    ctrlWr(8'h00);
    check("ra req", 16'(vram_req), 16'h1);
    check("ra we", 16'(vram_we), 16'h0);
    check("ra addr", 16'(vram_addr), 16'h0000);
    ackNow(8'h5C);
    check("ra busy", 16'(busy), 16'h0);
    rdPort(1'b1, 1'b0, 1'b0);
    check("drd cd_out", 16'(cd_out), 16'h005C);
    check("drd req", 16'(vram_req), 16'h1);
    check("drd addr", 16'(vram_addr), 16'h0001);
    check("drd we", 16'(vram_we), 16'h0);
    ackNow(8'h77);

    // register writes
    ctrlWr(8'h0F);
    ctrlWr(8'h81);
    check("reg_we", 16'(reg_we), 16'h1);
    check("reg_addr", 16'(reg_addr), 16'h1);
    check("reg_data", 16'(reg_data), 16'h0F);
    cyc();
    check("reg_we pulse end", 16'(reg_we), 16'h0);
    ctrlWr(8'h00);
    ctrlWr(8'h8C);
    check("reg_we idx12 dropped", 16'(reg_we), 16'h0);

    // CRAM writes with 5-bit index wrap
    ctrlWr(8'h1F);
    ctrlWr(8'hC0);
    dataWr(8'h11);
    check("cram_we 1", 16'(cram_we), 16'h1);
    check("cram_addr 1", 16'(cram_addr), 16'h1F);
    check("cram_data 1", 16'(cram_data), 16'h11);
    check("cram no vram", 16'(busy), 16'h0);
    dataWr(8'h22);
    check("cram_we 2", 16'(cram_we), 16'h1);
    check("cram_addr 2", 16'(cram_addr), 16'h00);
    check("cram_data 2", 16'(cram_data), 16'h22);
    cyc();
    check("cram_we end", 16'(cram_we), 16'h0);
    // data read exposes addr 0x0021 and the buffered 0x77
    rdPort(1'b1, 1'b0, 1'b0);
    check("cram addr after", 16'(vram_addr), 16'h0021);
    check("cram rbuf", 16'(cd_out), 16'h0077);
    ackNow(8'h66);

    // wrap at 0x3FFF; strobe during busy ignored
    ctrlWr(8'hFF);
    ctrlWr(8'h7F);
    dataWr(8'h33);
    check("wrap addr 3FFF", 16'(vram_addr), 16'h3FFF);
    dataWr(8'h99);
    check("busy strobe wdata", 16'(vram_wdata), 16'h0033);
    check("busy strobe addr", 16'(vram_addr), 16'h3FFF);
    ackNow(8'h00);
    dataWr(8'h44);
    check("wrap addr 0000", 16'(vram_addr), 16'h0000);
    check("wrap wdata", 16'(vram_wdata), 16'h0044);
    ackNow(8'h00);
    rdPort(1'b1, 1'b0, 1'b0);
    check("rbuf from write", 16'(cd_out), 16'h0044);
    check("rd after wrap addr", 16'(vram_addr), 16'h0001);
    ackNow(8'h00);

    // PSG write gated by psg_ready
    psg_ready = 1'b0;
    psgPulses = 0;
    wrPort(1'b0, 1'b1, 1'b0, 8'h9F);
    cd_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      check("psg wait busy", 16'(busy), 16'h1);
      if (psg_we) psgPulses++;
      cyc();
    end
    psg_ready = 1'b1;
    #1;
    check("psg_we on ready", 16'(psg_we), 16'h1);
    check("psg_data", 16'(psg_data), 16'h009F);
    if (psg_we) psgPulses++;
    cyc();
    if (psg_we) psgPulses++;
    check("psg busy done", 16'(busy), 16'h0);
    cyc();
    if (psg_we) psgPulses++;
    check("psg one pulse", 16'(psgPulses), 16'h1);

    // status read clears the byte flag
    ctrlWr(8'h12);
    status_in = 8'hA5;
    rdPort(1'b1, 1'b0, 1'b1);
    check("status cd_out", 16'(cd_out), 16'h00A5);
    check("status_rd", 16'(status_rd), 16'h1);
    cyc();
    check("status_rd end", 16'(status_rd), 16'h0);
    ctrlWr(8'h56);
    ctrlWr(8'h00);
    check("flag cleared req", 16'(vram_req), 16'h1);
    check("flag cleared addr", 16'(vram_addr), 16'h0056);
    ackNow(8'h00);

    // low-port read, then simultaneous write/read (write wins)
    rdPort(1'b0, 1'b0, 1'b0);
    check("low read FF", 16'(cd_out), 16'h00FF);
    io_rd = 1'b1;
    dataWr(8'hBE);
    io_rd = 1'b0;
    check("wr wins we", 16'(vram_we), 16'h1);
    check("wr wins addr", 16'(vram_addr), 16'h0057);
    check("wr wins cd_out", 16'(cd_out), 16'h00FF);
    ackNow(8'h00);

    // reset mid-access drops the request
    rdPort(1'b1, 1'b0, 1'b0);
    check("pre-reset req", 16'(vram_req), 16'h1);
    #1 reset = 1'b1;
    #1;
    check("reset drops req", 16'(vram_req), 16'h0);
    check("reset busy", 16'(busy), 16'h0);
    check("reset cd_out", 16'(cd_out), 16'h00);
    cyc();
    reset = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
